// File: rtl/wb_data_ram_pkg.sv
// ============================================================================
// Module   : wb_data_ram_pkg
// Brief    : Shared state codes, constants and helpers for the Wishbone data RAM
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_data_ram_pkg;

  localparam logic [1:0]  c_wb_idle    = 2'd0;
  localparam logic [1:0]  c_wb_wait    = 2'd1;
  localparam logic [1:0]  c_wb_resp    = 2'd2;
  localparam logic [31:0] c_zero_word  = 32'h0000_0000;
  localparam logic        c_rst_enable = 1'b1;
  localparam logic [3:0]  c_wb_sel_all = 4'b1111;
  localparam int          c_cnt_w      = 4;

  typedef enum logic [1:0] {
    S_IDLE = c_wb_idle,
    S_WAIT = c_wb_wait,
    S_RESP = c_wb_resp
  } wb_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_req_t;

  // Word-aligned and inside the array; anything else terminates with err.
  function automatic logic addr_ok(input logic [31:0] adr, input int mem_words);
    return (adr[1:0] == 2'b00) && ({2'b00, adr[31:2]} < 32'(mem_words));
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_data_ram_array.sv
// ============================================================================
// Module   : data_ram_array
// Brief    : MEM_WORDS x 32 storage, per-byte-lane synchronous write, async read
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_array #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic [3:0]    lane_we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // One byte-wide array per lane keeps each lane's writer independent.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_mem [MEM_WORDS];

    always_ff @(posedge clk) begin
      if (lane_we[g]) begin
        r_mem[addr] <= wdata[8*g +: 8];
      end
    end

    assign rdata[8*g +: 8] = r_mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/wb_data_ram.sv
// ============================================================================
// Module   : wb_data_ram
// Brief    : Wishbone-classic data RAM slave with programmable wait states
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_data_ram
  import wb_data_ram_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  wb_state_e            r_state;
  wb_state_e            w_next;
  logic [c_cnt_w-1:0]   r_cnt;
  wb_req_t              r_req;
  logic                 r_ack;
  logic                 r_err;
  logic [31:0]          r_dat;

  logic                 w_capture;
  logic                 w_enter_resp;
  logic                 w_ok;
  logic [3:0]           w_lane_we;
  logic [31:0]          w_rdata;

  assign w_ok = addr_ok(r_req.adr, MEM_WORDS);

  always_comb begin
    w_next       = r_state;
    w_capture    = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          w_capture = 1'b1;
          w_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          w_next = S_IDLE;
        end else if (r_cnt == '0) begin
          w_enter_resp = 1'b1;
          w_next       = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Write commits on the same edge that raises ack, so a following read sees it.
  assign w_lane_we = r_req.sel
                   & ((w_enter_resp && w_ok && r_req.we) ? c_wb_sel_all : 4'b0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == c_rst_enable) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= c_zero_word;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_req <= '{we: wb_we_i, adr: wb_adr_i, sel: wb_sel_i, dat: wb_dat_i};
        r_cnt <= c_cnt_w'(WAIT_STATES);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_ack <= w_enter_resp && w_ok;
      r_err <= w_enter_resp && !w_ok;
      r_dat <= (w_enter_resp && w_ok && !r_req.we) ? w_rdata : c_zero_word;
    end
  end

  data_ram_array #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_array (
    .clk     (clk),
    .lane_we (w_lane_we),
    .addr    (r_req.adr[AW+1:2]),
    .wdata   (r_req.dat),
    .rdata   (w_rdata)
  );

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_data_ram.sv
// Directed bench for wb_data_ram: table-driven bus vectors plus latency, abort and reset sequences.
`default_nettype none

module tb_wb_data_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] dat_o [3];
  logic        ack   [3];
  logic        err   [3];

  int edge_cnt = 0;
  int errors   = 0;
  int checks   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  // Index 0: WAIT_STATES=2, index 1: WAIT_STATES=3, index 2: WAIT_STATES=0.
  wb_data_ram #(.MEM_WORDS(1024), .WAIT_STATES(2)) u_w2 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i),
    .wb_dat_o(dat_o[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]));
  wb_data_ram #(.MEM_WORDS(1024), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i),
    .wb_dat_o(dat_o[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]));
  wb_data_ram #(.MEM_WORDS(1024), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc[2]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i),
    .wb_dat_o(dat_o[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]));

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_ack;
    logic        exp_err;
    logic        chk_dat;
    logic [31:0] exp_dat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus transaction on DUT k; lat = posedges from driving the request to seeing ack/err.
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic g_ack, output logic g_err,
                     output logic [31:0] g_dat, output int lat);
    int start;
    @(negedge clk);
    cyc    = 3'b000;
    cyc[k] = 1'b1;
    stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    start = edge_cnt;
    g_ack = 1'b0; g_err = 1'b0; g_dat = '0; lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack[k] || err[k]) begin
        g_ack = ack[k]; g_err = err[k]; g_dat = dat_o[k];
        lat = edge_cnt - start;
        break;
      end
    end
    cyc = 3'b000;
    stb = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: dut %0d adr %h got no ack/err within 40 cycles", k, a);
    end
  endtask

  vec_t        vecs [17];
  logic        g_ack, g_err;
  logic [31:0] g_dat;
  int          lat;
  logic        seen;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1234_5678};
    vecs[2]  = '{1'b1, 32'h0000_0010, 4'b0100, 32'h00AB_0000, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,         1'b1, 1'b0, 1'b1, 32'h12AB_5678};
    vecs[4]  = '{1'b1, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_1000, 4'b1111, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0012, 4'b1111, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_0012, 4'b1111, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0,         1'b1, 1'b0, 1'b1, 32'h12AB_5678};
    vecs[9]  = '{1'b1, 32'h0000_0014, 4'b1111, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_0014, 4'b0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_0014, 4'b1001, 32'h1122_3344, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0014, 4'b1111, 32'h0,         1'b1, 1'b0, 1'b1, 32'h11A5_A544};
    vecs[13] = '{1'b1, 32'h0000_0FFC, 4'b1111, 32'h7654_3210, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_0FFC, 4'b1111, 32'h0,         1'b1, 1'b0, 1'b1, 32'h7654_3210};
    vecs[15] = '{1'b0, 32'hFFFF_FFF0, 4'b1111, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
    vecs[16] = '{1'b1, 32'h0000_0011, 4'b1111, 32'h0BAD_0BAD, 1'b0, 1'b1, 1'b1, 32'h0};

    rst = 1'b1; cyc = 3'b000; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_i = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_outputs dut%0d", k), {29'd0, ack[k], err[k], |dat_o[k]}, 64'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      txn(0, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, g_ack, g_err, g_dat, lat);
      check($sformatf("vec%0d ack_err_dat", i),
            {30'd0, g_ack, g_err, (vecs[i].chk_dat ? g_dat : 32'h0)},
            {30'd0, vecs[i].exp_ack, vecs[i].exp_err, vecs[i].exp_dat});
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
    end

    // Termination must last exactly one cycle.
    txn(0, 1'b0, 32'h10, 4'hF, 32'h0, g_ack, g_err, g_dat, lat);
    @(negedge clk);
    check("w2 ack_drops_after_one_cycle", {63'd0, ack[0]}, 64'd0);

    // Zero wait states: ack one edge after the request edge.
    txn(2, 1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, g_ack, g_err, g_dat, lat);
    check("w0 write latency", 64'(lat), 64'd2);
    @(negedge clk);
    check("w0 ack_drops_after_one_cycle", {63'd0, ack[2]}, 64'd0);
    txn(2, 1'b0, 32'h0, 4'hF, 32'h0, g_ack, g_err, g_dat, lat);
    check("w0 read data", {31'd0, g_ack, g_dat}, {31'd0, 1'b1, 32'h0BAD_F00D});
    check("w0 read latency", 64'(lat), 64'd2);

    // Abort: cyc dropped while waiting must neither terminate nor write.
    txn(1, 1'b1, 32'h20, 4'hF, 32'h1111_1111, g_ack, g_err, g_dat, lat);
    check("w3 write latency", 64'(lat), 64'd5);
    @(negedge clk);
    cyc = 3'b010; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    cyc = 3'b000; stb = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | ack[1] | err[1];
    end
    check("abort no_ack_err", {63'd0, seen}, 64'd0);
    txn(1, 1'b0, 32'h20, 4'hF, 32'h0, g_ack, g_err, g_dat, lat);
    check("abort old_value", {31'd0, g_ack, g_dat}, {31'd0, 1'b1, 32'h1111_1111});

    // Reset arriving mid-cycle while ack is high clears outputs without a clock edge.
    @(negedge clk);
    cyc = 3'b001; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check("pre_reset ack_data", {31'd0, seen, dat_o[0]}, {31'd0, 1'b1, 32'h12AB_5678});
    #1 rst = 1'b1;
    #1;
    check("async_reset outputs", {31'd0, ack[0], dat_o[0]}, 64'd0);
    cyc = 3'b000; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Reset during WAIT drops the pending write.
    @(negedge clk);
    cyc = 3'b001; stb = 1'b1; we = 1'b1; adr = 32'h10; sel = 4'hF; dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_in_wait outputs", {30'd0, ack[0], err[0], dat_o[0]}, 64'd0);
    cyc = 3'b000; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    txn(0, 1'b0, 32'h10, 4'hF, 32'h0, g_ack, g_err, g_dat, lat);
    check("after_reset no_write", {31'd0, g_ack, g_dat}, {31'd0, 1'b1, 32'h12AB_5678});
    check("after_reset latency", 64'(lat), 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
